pll_lock_sequencer: RTL and testbench

Power-up and lock-loss sequencer for the 40 MHz pixel-clock PLL. It runs on the free-running PLL reference clock and drives the PLL's asynchronous reset. It watches the PLL lock flag and holds the VGA pixel-domain logic in reset until lock has been stable for a qualifying period. On lock loss it re-sequences the PLL, and it declares a fault after repeated lock failures.

---
 rtl/pll_lock_sequencer.sv | 139 +++++++++++++
 tb/tb_pll_lock_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// Sequences the pixel-clock PLL reset and holds the video domain in reset until lock is stable.
// Optional lock-loss counter: define PLL_SEQ_LOSS_CNT_EN to implement loss_cnt (tied to 0 otherwise).
module pll_lock_sequencer #(
  parameter int AR_CYCLES     = 16,
  parameter int LOCK_TIMEOUT  = 10000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          pll_locked,
  input  logic          restart,
  output logic          pll_areset,
  output logic          video_rst_n,
  output logic          ready,
  output logic          fault,
  output logic [RW-1:0] retry_cnt,
  output logic [7:0]    loss_cnt
);

  localparam int CNT_MAX_AT = (AR_CYCLES > LOCK_TIMEOUT) ? AR_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX    = (CNT_MAX_AT > STABLE_CYCLES) ? CNT_MAX_AT : STABLE_CYCLES;
  localparam int CW         = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] AR_LAST     = CW'(AR_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST     = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [RW-1:0] retry_reg, retry_next;
  logic [1:0]    sync_reg;
  logic          locked_s;

  assign locked_s = sync_reg[1];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    retry_next = retry_reg;
    if (restart) begin
      state_next = S_RESET_PLL;
      retry_next = '0;
    end else begin
      case (state_reg)
        S_RESET_PLL: begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == AR_LAST) state_next = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          cnt_next = cnt_reg + 1'b1;
          if (locked_s) begin
            state_next = S_STABLE;
          end else if (cnt_reg == TO_LAST) begin
            if (retry_reg == RETRY_LIMIT) begin
              state_next = S_FAULT;
            end else begin
              retry_next = retry_reg + 1'b1;
              state_next = S_RESET_PLL;
            end
          end
        end
        S_STABLE: begin
          cnt_next = cnt_reg + 1'b1;
          if (!locked_s) begin
            state_next = S_WAIT_LOCK;
          end else if (cnt_reg == ST_LAST) begin
            state_next = S_RUN;
            retry_next = '0;
          end
        end
        S_RUN: begin
          if (!locked_s) state_next = S_RESET_PLL;
        end
        S_FAULT: begin
        end
        default: state_next = S_RESET_PLL;
      endcase
    end
    // Every state entry (including a restart into RESET_PLL) starts the shared counter from zero.
    if (restart || (state_next != state_reg)) cnt_next = '0;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg    <= '0;
      state_reg   <= S_RESET_PLL;
      cnt_reg     <= '0;
      retry_reg   <= '0;
      pll_areset  <= 1'b1;
      video_rst_n <= 1'b0;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[0], pll_locked};
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      retry_reg   <= retry_next;
      // Outputs decoded from the next state so they switch on the same edge as the state.
      pll_areset  <= (state_next == S_RESET_PLL) || (state_next == S_FAULT);
      video_rst_n <= (state_next == S_RUN);
      ready       <= (state_next == S_RUN);
      fault       <= (state_next == S_FAULT);
    end
  end

  assign retry_cnt = retry_reg;

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0] loss_reg;
  logic       loss_event;

  // A restart wins over a simultaneous lock loss, so that edge is not counted.
  assign loss_event = (state_reg == S_RUN) && !restart && !locked_s;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      loss_reg <= '0;
    end else if (loss_event && (loss_reg != 8'hFF)) begin
      loss_reg <= loss_reg + 1'b1;
    end
  end

  assign loss_cnt = loss_reg;
`else
  assign loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: directed test-plan scenarios plus random lock chatter,
// checked against a phase/elapsed-time reference model.
module tb_pll_lock_sequencer;

  localparam int AR = 4;
  localparam int TO = 20;
  localparam int ST = 8;
  localparam int MR = 2;
  localparam int RW = 2;
`ifdef PLL_SEQ_LOSS_CNT_EN
  localparam int LOSS_SAT = 255;
`else
  localparam int LOSS_SAT = 0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_n;
  logic          pll_locked;
  logic          restart;
  logic          pll_areset;
  logic          video_rst_n;
  logic          ready;
  logic          fault;
  logic [RW-1:0] retry_cnt;
  logic [7:0]    loss_cnt;

  pll_lock_sequencer #(
    .AR_CYCLES    (AR),
    .LOCK_TIMEOUT (TO),
    .STABLE_CYCLES(ST),
    .MAX_RETRIES  (MR)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_areset (pll_areset),
    .video_rst_n(video_rst_n),
    .ready      (ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic          pa;
    logic          vr;
    logic          rd;
    logic          ft;
    logic [RW-1:0] rc;
    logic [7:0]    lc;
  } exp_t;

  exp_t scb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: named phase, time spent in it, attempt/loss tallies, and a 2-deep lock delay line.
  typedef enum int {P_RESET, P_WAIT, P_STABLE, P_RUN, P_FAULT} phase_t;
  phase_t m_phase;
  int     m_elapsed;
  int     m_retries;
  int     m_losses;
  bit     m_delay[$];

  task automatic model_reset();
    m_phase   = P_RESET;
    m_elapsed = 0;
    m_retries = 0;
    m_losses  = 0;
    m_delay   = {};
    m_delay.push_back(1'b0);
    m_delay.push_back(1'b0);
  endtask

  task automatic enter(input phase_t p);
    m_phase   = p;
    m_elapsed = 0;
  endtask

  task automatic model_step();
    bit ls;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ls = m_delay.pop_front();
    m_delay.push_back(pll_locked);
    if (restart) begin
      enter(P_RESET);
      m_retries = 0;
      return;
    end
    case (m_phase)
      P_RESET: begin
        m_elapsed++;
        if (m_elapsed == AR) enter(P_WAIT);
      end
      P_WAIT: begin
        if (ls) begin
          enter(P_STABLE);
        end else begin
          m_elapsed++;
          if (m_elapsed == TO) begin
            if (m_retries == MR) enter(P_FAULT);
            else begin
              m_retries++;
              enter(P_RESET);
            end
          end
        end
      end
      P_STABLE: begin
        if (!ls) enter(P_WAIT);
        else begin
          m_elapsed++;
          if (m_elapsed == ST) begin
            enter(P_RUN);
            m_retries = 0;
          end
        end
      end
      P_RUN: begin
        if (!ls) begin
          enter(P_RESET);
          if (m_losses < LOSS_SAT) m_losses++;
        end
      end
      default: begin
      end
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.pa = (m_phase == P_RESET) || (m_phase == P_FAULT);
    e.vr = (m_phase == P_RUN);
    e.rd = (m_phase == P_RUN);
    e.ft = (m_phase == P_FAULT);
    e.rc = RW'(m_retries);
    e.lc = 8'(m_losses);
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // One clock of stimulus: drive, predict the post-edge outputs, and move to the next falling edge.
  task automatic cyc(input bit lk, input bit rs);
    pll_locked = lk;
    restart    = rs;
    model_step();
    scb_q.push_back(model_out());
    @(negedge clk_in);
  endtask

  task automatic run_until_ready(input int limit, output int took);
    took = -1;
    for (int i = 1; i <= limit; i++) begin
      cyc(1'b1, 1'b0);
      if (ready === 1'b1) begin
        took = i;
        break;
      end
    end
  endtask

  // Monitor: every rising edge (and an asynchronous reset assertion) presents a new output vector.
  initial begin
    exp_t e;
    exp_t act;
    forever begin
      @(posedge clk_in or negedge rst_n);
      #1;
      if (scb_q.size() > 0) begin
        e   = scb_q.pop_front();
        act = {pll_areset, video_rst_n, ready, fault, retry_cnt, loss_cnt};
        n_vec++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL outputs @%0t: got pa=%b vr=%b rd=%b ft=%b rc=%0d lc=%0d, required pa=%b vr=%b rd=%b ft=%b rc=%0d lc=%0d",
                   $time, act.pa, act.vr, act.rd, act.ft, act.rc, act.lc,
                   e.pa, e.vr, e.rd, e.ft, e.rc, e.lc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edge_at;
    int lat;
    int pa_at;
    int took;
    int resync_errs;
    bit lk;

    rst_n      = 1'b0;
    pll_locked = 1'b0;
    restart    = 1'b0;
    model_reset();
    @(negedge clk_in);
    repeat (3) cyc(1'b0, 1'b0);

    // Clean bring-up: areset falls on edge AR, lock 10 cycles after release.
    rst_n   = 1'b1;
    edge_at = -1;
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b0, 1'b0);
      if (edge_at < 0 && pll_areset === 1'b0) edge_at = i;
    end
    check("bringup_areset_fall_edge", edge_at, AR);
    run_until_ready(40, took);
    check("bringup_lock_to_ready", took, 2 + ST + 1);

    // Lock loss in RUN: one low cycle reaches the outputs on the third edge.
    lat   = -1;
    pa_at = -1;
    for (int i = 1; i <= 6; i++) begin
      cyc(i != 1, 1'b0);
      if (lat < 0 && video_rst_n === 1'b0) begin
        lat   = i;
        pa_at = int'(pll_areset);
      end
    end
    check("loss_vrst_latency", lat, 3);
    check("loss_areset_same_edge", pa_at, 1);
    run_until_ready(40, took);
    check("loss_resequence", int'(took > 0), 1);
    check("loss_cnt_first", int'(loss_cnt), (LOSS_SAT > 0) ? 1 : 0);

    resync_errs = 0;
    for (int n = 0; n < 299; n++) begin
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      if (ready !== 1'b0) resync_errs++;
      run_until_ready(40, took);
      if (took < 0) resync_errs++;
    end
    check("loss_repeat_errors", resync_errs, 0);
    check("loss_cnt_saturated", int'(loss_cnt), LOSS_SAT);

    // Lock chatter in STABLE after one failed attempt.
    cyc(1'b0, 1'b1);
    repeat (AR + TO) cyc(1'b0, 1'b0);
    check("chatter_first_timeout_retry", int'(retry_cnt), 1);
    repeat (5) cyc(1'b0, 1'b0);
    repeat (5) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    check("chatter_retry_unchanged", int'(retry_cnt), 1);
    run_until_ready(40, took);
    check("chatter_release_edge", took, 10);
    check("chatter_retry_cleared", int'(retry_cnt), 0);

    // Lock never arrives: three full attempts, then FAULT held.
    cyc(1'b0, 1'b1);
    edge_at = -1;
    for (int i = 1; i <= 100; i++) begin
      cyc(1'b0, 1'b0);
      if (edge_at < 0 && fault === 1'b1) edge_at = i;
    end
    check("nolock_fault_edge", edge_at, (MR + 1) * (AR + TO));
    check("nolock_fault_held", int'({fault, pll_areset, video_rst_n, ready}), 4'b1100);
    check("nolock_retry_at_fault", int'(retry_cnt), MR);
    cyc(1'b0, 1'b1);
    check("restart_clears_fault", int'({fault, pll_areset, retry_cnt}), {1'b0, 1'b1, 2'd0});
    edge_at = -1;
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b0);
      if (edge_at < 0 && pll_areset === 1'b0) edge_at = i;
    end
    check("restart_areset_fall_edge", edge_at, AR);

    // Random lock chatter with occasional restarts.
    lk = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) lk = ~lk;
      cyc(lk, $urandom_range(0, 299) == 0);
    end

    // Asynchronous reset in the middle of STABLE.
    cyc(1'b1, 1'b1);
    repeat (AR + 3) cyc(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    scb_q.push_back(model_out());
    #2;
    check("async_reset_no_edge", int'({pll_areset, video_rst_n, loss_cnt}), {1'b1, 1'b0, 8'd0});
    model_step();
    scb_q.push_back(model_out());
    @(negedge clk_in);
    repeat (2) cyc(1'b1, 1'b0);
    rst_n = 1'b1;
    run_until_ready(40, took);
    check("post_reset_bringup", took, AR + 1 + ST);

    repeat (3) cyc(1'b1, 1'b0);
    check("scoreboard_drain", scb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
